// File: rtl/zeroriscy_multdiv_ctrl.sv
// Multiply/divide request controller: issues latched operands to the
// iterative unit, tracks flush/timeout and returns one response.
module zeroriscy_multdiv_ctrl #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        flush_i,
  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output logic [1:0]  md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  output logic        md_equal_to_zero_o,
  input  logic [32:0] md_alu_operand_a_i,
  input  logic [32:0] md_alu_operand_b_i,
  output logic [33:0] md_alu_adder_ext_o,
  output logic [31:0] md_alu_adder_o,
  input  logic [31:0] md_result_i,
  input  logic        md_ready_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          run;

  assign md_alu_adder_ext_o = {1'b0, md_alu_operand_a_i}
                            + {1'b0, md_alu_operand_b_i};
  assign md_alu_adder_o = md_alu_adder_ext_o[32:1];

  assign run          = (state == ISSUE) || (state == DRAIN);
  assign md_mult_en_o = run & ~md_operator_o[1];
  assign md_div_en_o  = run & md_operator_o[1];
  assign req_ready_o  = (state == IDLE) & ~flush_i;
  assign rsp_valid_o  = (state == RESP);
  assign busy_o       = (state != IDLE);

  // Request latch, issue/drain/response sequencing and the timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      md_operator_o      <= '0;
      md_signed_mode_o   <= '0;
      md_op_a_o          <= '0;
      md_op_b_o          <= '0;
      md_equal_to_zero_o <= 1'b0;
      rsp_result_o       <= '0;
      rsp_err_o          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            md_operator_o      <= operator_i;
            md_signed_mode_o   <= signed_mode_i;
            md_op_a_o          <= op_a_i;
            md_op_b_o          <= op_b_i;
            md_equal_to_zero_o <= (op_b_i == 32'd0);
            cnt                <= '0;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (md_ready_i) begin
            if (!flush_i) begin
              rsp_result_o <= md_result_i;
              rsp_err_o    <= 1'b0;
              state        <= RESP;
            end else begin
              state <= IDLE;
            end
          end else if (flush_i) begin
            state <= DRAIN;
          end else if (cnt == CNT_LAST) begin
            rsp_result_o <= '0;
            rsp_err_o    <= 1'b1;
            state        <= RESP;
          end
        end
        DRAIN: begin
          if (md_ready_i) state <= IDLE;
        end
        RESP: begin
          if (flush_i || rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zeroriscy_multdiv_ctrl.sv
// Randomized bench for zeroriscy_multdiv_ctrl with an arithmetic
// reference for the multiply/divide results.
module tb_zeroriscy_multdiv_ctrl;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  operator;
  logic [1:0]  signed_mode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        md_mult_en;
  logic        md_div_en;
  logic [1:0]  md_operator;
  logic [1:0]  md_signed_mode;
  logic [31:0] md_op_a;
  logic [31:0] md_op_b;
  logic        md_eqz;
  logic [32:0] alu_a;
  logic [32:0] alu_b;
  logic [33:0] adder_ext;
  logic [31:0] adder;
  logic [31:0] md_result;
  logic        md_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  zeroriscy_multdiv_ctrl #(.TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .operator_i         (operator),
    .signed_mode_i      (signed_mode),
    .op_a_i             (op_a),
    .op_b_i             (op_b),
    .flush_i            (flush),
    .md_mult_en_o       (md_mult_en),
    .md_div_en_o        (md_div_en),
    .md_operator_o      (md_operator),
    .md_signed_mode_o   (md_signed_mode),
    .md_op_a_o          (md_op_a),
    .md_op_b_o          (md_op_b),
    .md_equal_to_zero_o (md_eqz),
    .md_alu_operand_a_i (alu_a),
    .md_alu_operand_b_i (alu_b),
    .md_alu_adder_ext_o (adder_ext),
    .md_alu_adder_o     (adder),
    .md_result_i        (md_result),
    .md_ready_i         (md_ready),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_result_o       (rsp_result),
    .rsp_err_o          (rsp_err),
    .busy_o             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [1:0] op,
                                         input logic [1:0] sm,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, p;
    sa = sm[0] ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sm[1] ? longint'($signed(b)) : longint'({32'd0, b});
    p = 0;
    case (op)
      2'd0: p = sa * sb;
      2'd1: begin p = sa * sb; p = p >>> 32; end
      2'd2: p = (b == 0) ? -1 : sa / sb;
      default: p = (b == 0) ? sa : sa % sb;
    endcase
    return p[31:0];
  endfunction

  task automatic rand_alu();
    alu_a = {1'($urandom), 32'($urandom)};
    alu_b = {1'($urandom), 32'($urandom)};
  endtask

  task automatic chk_alu();
    logic [33:0] e;
    e = 34'(alu_a) + 34'(alu_b);
    chk("adder_ext", adder_ext, e);
    chk("adder", adder, e[32:1]);
  endtask

  // lat: enable cycle in which the unit reports ready (0 = never)
  // fl: enable cycle with a flush pulse (0 = none)
  // bp: response cycles held off; rfl: flush the response instead
  task automatic do_op(input logic [1:0] op, input logic [1:0] sm,
                       input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int fl, input int bp,
                       input bit rfl);
    logic [31:0] want, res;
    bit done, flushed, to_resp, err;
    int k;
    want = ref_md(op, sm, a, b);
    res = 0; err = 0; to_resp = 0; done = 0; flushed = 0;
    @(negedge clk);
    req_valid = 1; operator = op; signed_mode = sm;
    op_a = a; op_b = b; flush = 0; md_ready = 0; rand_alu();
    #1;
    chk("req_ready_hs", req_ready, 1);
    chk("en_idle", md_mult_en | md_div_en, 0);
    chk_alu();
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    operator = 2'($urandom); signed_mode = 2'($urandom);
    op_a = $urandom; op_b = $urandom;
    k = 1;
    while (!done) begin
      md_ready = (k == lat);
      md_result = md_ready ? want : $urandom;
      flush = (k == fl);
      rand_alu();
      #1;
      chk("mult_en", md_mult_en, !op[1]);
      chk("div_en", md_div_en, op[1]);
      chk("busy_run", busy, 1);
      chk("rsp_valid_run", rsp_valid, 0);
      chk("req_ready_run", req_ready, 0);
      chk_alu();
      if (k == 1) begin
        chk("md_operator", md_operator, op);
        chk("md_signed", md_signed_mode, sm);
        chk("md_op_a", md_op_a, a);
        chk("md_op_b", md_op_b, b);
        chk("md_eqz", md_eqz, b == 0);
      end
      if (md_ready) begin
        done = 1; to_resp = !flushed && !flush; res = want; err = 0;
      end else if (flush) begin
        flushed = 1;
      end else if (!flushed && k == TO) begin
        done = 1; to_resp = 1; res = 0; err = 1;
      end
      @(posedge clk);
      if (!done) begin
        @(negedge clk);
        k++;
        if (k > 200) begin
          chk("issue_bound", k, 0);
          done = 1;
        end
      end
    end
    if (to_resp) begin
      for (int j = 0; j <= bp; j++) begin
        @(negedge clk);
        md_ready = 1'($urandom); md_result = $urandom;
        rsp_ready = (j == bp) && !rfl;
        flush = (j == bp) && rfl;
        rand_alu();
        #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_result", rsp_result, res);
        chk("rsp_err", rsp_err, err);
        chk("en_resp", md_mult_en | md_div_en, 0);
        chk("req_ready_resp", req_ready, 0);
        chk_alu();
        @(posedge clk);
      end
    end
    @(negedge clk);
    flush = 0; rsp_ready = 0; md_ready = 0;
    #1;
    chk("rsp_valid_end", rsp_valid, 0);
    chk("busy_end", busy, 0);
    chk("req_ready_end", req_ready, 1);
    chk("en_end", md_mult_en | md_div_en, 0);
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    req_valid = 1; operator = 2; signed_mode = 0;
    op_a = 32'd55; op_b = 32'd5; flush = 0; md_ready = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_en", md_mult_en | md_div_en, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_op_a", md_op_a, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rel_req_ready", req_ready, 1);
    flush = 1;
    #1;
    chk("flush_req_ready", req_ready, 0);
    flush = 0;
  endtask

  initial begin
    int lat, fl;
    logic [31:0] a, b;
    rst_n = 0; req_valid = 0; operator = 0; signed_mode = 0;
    op_a = 0; op_b = 0; flush = 0; alu_a = 0; alu_b = 0;
    md_result = 0; md_ready = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_err", rsp_err, 0);
    chk("reset_en", md_mult_en | md_div_en, 0);
    chk("reset_op_b", md_op_b, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_req_ready", req_ready, 1);

    do_op(2'd0, 2'b00, 32'd7, 32'd6, 3, 0, 0, 0);
    do_op(2'd2, 2'b00, 32'd100, 32'd0, 4, 0, 1, 0);
    do_op(2'd3, 2'b00, 32'd100, 32'd0, 2, 0, 0, 0);
    do_op(2'd2, 2'b11, -32'sd20, 32'd3, 6, 0, 0, 0);
    do_op(2'd3, 2'b11, -32'sd20, 32'd3, 6, 0, 0, 0);
    do_op(2'd2, 2'b00, 32'd1000, 32'd7, 12, 5, 0, 0);
    do_op(2'd1, 2'b11, 32'h8000_0000, 32'h7FFF_FFFF, 3, 0, 3, 0);
    do_op(2'd0, 2'b00, 32'd9, 32'd9, 0, 0, 1, 0);
    do_op(2'd1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, TO, 0, 0, 0);
    do_op(2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0, 0, 0);
    do_op(2'd0, 2'b00, 32'd3, 32'd4, 1, 0, 2, 1);
    do_op(2'd3, 2'b10, 32'd50, 32'd7, 4, 4, 0, 0);
    reset_mid_op();

    for (int i = 0; i < 150; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 0;
      if ($urandom_range(0, 15) == 0) begin
        a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end
      lat = $urandom_range(0, TO + 3);
      fl = 0;
      if (lat != 0 && $urandom_range(0, 3) == 0)
        fl = $urandom_range(1, lat);
      do_op(2'($urandom), 2'($urandom), a, b, lat, fl,
            $urandom_range(0, 3), $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        md_ready = 1;
        #1;
        chk("idle_ready_ignored", busy, 0);
        @(posedge clk);
        @(negedge clk);
        md_ready = 0;
        #1;
        chk("idle_stays", busy, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
